// File: rtl/pipe_delay_pkg.sv
// rtl/pipe_delay_pkg.sv - shared defaults and sizing helper for the delay line
package pipe_delay_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one data+valid register stage with reset, flush and advance
module pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    // Stage register: reset beats flush beats advance; flush drops valid but keeps data.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else if (flush) begin
            q_vld <= 1'b0;
        end else if (en) begin
            q     <= d;
            q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/pipe_delay_line.sv
// rtl/pipe_delay_line.sv - stallable DEPTH-stage delay line with valid tracking and occupancy
module pipe_delay_line
    import pipe_delay_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              OCC_W   = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [OCC_W-1:0] occ
);

    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (i == 0) begin : g_head
            assign d_in = din;
            assign v_in = din_vld;
        end else begin : g_link
            assign d_in = stage_data[i-1];
            assign v_in = stage_vld[i-1];
        end

        pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .en    (en),
            .d     (d_in),
            .d_vld (v_in),
            .q     (stage_data[i]),
            .q_vld (stage_vld[i])
        );
    end

    assign dout     = stage_data[DEPTH-1];
    assign dout_vld = stage_vld[DEPTH-1];

    // Occupancy: +1 on valid entry, -1 on valid exit, unchanged when both or neither.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ <= '0;
        end else if (en) begin
            if (din_vld && !stage_vld[DEPTH-1]) begin
                occ <= occ + OCC_ONE;
            end else if (!din_vld && stage_vld[DEPTH-1]) begin
                occ <= occ - OCC_ONE;
            end
        end
    end

`ifndef SYNTHESIS
    logic             chk_armed;
    logic             prev_rst;
    logic             prev_hold;
    logic [WIDTH-1:0] prev_dout;
    logic             prev_dout_vld;
    logic [OCC_W-1:0] prev_occ;

    // Checkers compare current outputs against what the previous cycle's controls imply.
    always_ff @(posedge clk) begin
        chk_armed     <= chk_armed | rst;
        prev_rst      <= rst;
        prev_hold     <= !en && !rst && !flush;
        prev_dout     <= dout;
        prev_dout_vld <= dout_vld;
        prev_occ      <= occ;
        if (chk_armed) begin
            if (prev_rst) begin
                c1_reset_vals: assert (dout == RST_VAL && !dout_vld && occ == '0)
                    else $error("C1 reset values wrong: dout=%0h vld=%0b occ=%0d", dout, dout_vld, occ);
            end
            c2_occ_popcount: assert (occ == OCC_W'($countones(stage_vld)))
                else $error("C2 occ=%0d disagrees with valid bits %b", occ, stage_vld);
            if (prev_hold) begin
                c3_hold_stable: assert (dout == prev_dout && dout_vld == prev_dout_vld && occ == prev_occ)
                    else $error("C3 outputs moved during hold: dout=%0h vld=%0b occ=%0d", dout, dout_vld, occ);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// tb/tb_pipe_delay_line.sv - directed self-checking bench for pipe_delay_line
module tb_pipe_delay_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] din;
    logic       din_vld;
    logic [7:0] dout;
    logic       dout_vld;
    logic [2:0] occ;

    int checks = 0;
    int errors = 0;

    pipe_delay_line #(
        .WIDTH   (8),
        .DEPTH   (4),
        .RST_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .occ      (occ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vo(input string tag, input logic v, input logic [2:0] o);
        chk({tag, ".vld"}, 32'(dout_vld), 32'(v));
        chk({tag, ".occ"}, 32'(occ), 32'(o));
    endtask

    initial begin
        // 1: reset with junk on the inputs
        rst = 1'b1; en = 1'b1; flush = 1'b0; din = 8'hFF; din_vld = 1'b1;
        tick();
        chk("s1_rst1.dout", 32'(dout), 32'h00);
        chk_vo("s1_rst1", 1'b0, 3'd0);
        tick();
        chk("s1_rst2.dout", 32'(dout), 32'h00);
        chk_vo("s1_rst2", 1'b0, 3'd0);
        rst = 1'b0;

        // 2: push A1..A4 then bubbles
        din = 8'hA1; din_vld = 1'b1; tick(); chk_vo("s2_e1", 1'b0, 3'd1);
        din = 8'hA2;                 tick(); chk_vo("s2_e2", 1'b0, 3'd2);
        din = 8'hA3;                 tick(); chk_vo("s2_e3", 1'b0, 3'd3);
        din = 8'hA4;                 tick(); chk_vo("s2_e4", 1'b1, 3'd4);
        chk("s2_e4.dout", 32'(dout), 32'hA1);
        din = 8'h00; din_vld = 1'b0;
        tick(); chk_vo("s2_e5", 1'b1, 3'd3); chk("s2_e5.dout", 32'(dout), 32'hA2);
        tick(); chk_vo("s2_e6", 1'b1, 3'd2); chk("s2_e6.dout", 32'(dout), 32'hA3);
        tick(); chk_vo("s2_e7", 1'b1, 3'd1); chk("s2_e7.dout", 32'(dout), 32'hA4);
        tick(); chk_vo("s2_e8", 1'b0, 3'd0);

        // 3: push B1,B2, stall 3 cycles with live inputs, resume
        din = 8'hB1; din_vld = 1'b1; tick(); chk_vo("s3_b1", 1'b0, 3'd1);
        din = 8'hB2;                 tick(); chk_vo("s3_b2", 1'b0, 3'd2);
        en = 1'b0; din = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_vo("s3_stall", 1'b0, 3'd2);
            chk("s3_stall.dout", 32'(dout), 32'h00);
        end
        en = 1'b1; din = 8'h00; din_vld = 1'b0;
        tick(); chk_vo("s3_r1", 1'b0, 3'd2);
        tick(); chk_vo("s3_r2", 1'b1, 3'd2); chk("s3_r2.dout", 32'(dout), 32'hB1);
        tick(); chk_vo("s3_r3", 1'b1, 3'd1); chk("s3_r3.dout", 32'(dout), 32'hB2);
        tick(); chk_vo("s3_r4", 1'b0, 3'd0);

        // 4: three valid beats then flush while pushing C5
        din_vld = 1'b1;
        din = 8'hC1; tick();
        din = 8'hC2; tick();
        din = 8'hC3; tick(); chk_vo("s4_fill", 1'b0, 3'd3);
        flush = 1'b1; din = 8'hC5;
        tick(); chk_vo("s4_flush", 1'b0, 3'd0);
        flush = 1'b0; din = 8'h00; din_vld = 1'b0;
        tick(); chk_vo("s4_d1", 1'b0, 3'd0); chk("s4_d1.dout", 32'(dout), 32'hC1);
        tick(); chk_vo("s4_d2", 1'b0, 3'd0); chk("s4_d2.dout", 32'(dout), 32'hC2);
        tick(); chk_vo("s4_d3", 1'b0, 3'd0); chk("s4_d3.dout", 32'(dout), 32'hC3);
        tick(); chk_vo("s4_d4", 1'b0, 3'd0); chk("s4_d4.dout", 32'(dout), 32'h00);

        // 5: continuous stream D0..D9
        din_vld = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din = 8'hD0 + 8'(k);
            tick();
            if (k >= 3) begin
                chk_vo("s5_full", 1'b1, 3'd4);
                chk("s5_full.dout", 32'(dout), 32'hD0 + 32'(k - 3));
            end else begin
                chk_vo("s5_fill", 1'b0, 3'(k + 1));
            end
        end
        din = 8'h00; din_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_vo("s5_drain", 1'b1, 3'(3 - k));
            chk("s5_drain.dout", 32'(dout), 32'hD7 + 32'(k));
        end
        tick(); chk_vo("s5_empty", 1'b0, 3'd0);

        // 6: reset mid-stream with flush and en also high
        din_vld = 1'b1;
        din = 8'hE1; tick();
        din = 8'hE2; tick(); chk_vo("s6_pre", 1'b0, 3'd2);
        rst = 1'b1; flush = 1'b1;
        tick();
        chk("s6_rst.dout", 32'(dout), 32'h00);
        chk_vo("s6_rst", 1'b0, 3'd0);
        rst = 1'b0; flush = 1'b0; en = 1'b0; din_vld = 1'b0;
        tick(); chk_vo("s6_post", 1'b0, 3'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
